// File: rtl/jianpan_saomiao_pkg.sv
// Shared definitions for the keypad scanner: debounce states, frame results
// and the idle row drive pattern.
package jianpan_saomiao_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAND,
    ST_PRESSED,
    ST_REL
  } deb_state_e;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_SINGLE,
    RES_MULTI
  } frame_res_e;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  // Active-low one-hot row drive for a row index.
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/jianpan_saomiao_anjian_xiaodou.sv
// Per-frame debounce FSM: turns a stream of frame results into one accepted
// key event per physical press, with a matching debounced release.
module anjian_xiaodou
  import jianpan_saomiao_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       frame_strobe,
  input  frame_res_e result,
  input  logic [3:0] key,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

  deb_state_e state, state_n;
  logic [3:0] cnt, cnt_n, cnt_inc;
  logic [3:0] cand, cand_n;
  logic [3:0] code_n;
  logic       valid_n, held_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else if (!en) begin
      // key_code deliberately survives a disable; only reset clears it.
      state     <= ST_IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cand_n  = cand;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
    if (frame_strobe) begin
      unique case (state)
        ST_IDLE: begin
          if (result == RES_SINGLE) begin
            cand_n = key;
            if (DF <= 4'd1) begin
              state_n = ST_PRESSED;
              code_n  = key;
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
            end else begin
              state_n = ST_CAND;
              cnt_n   = 4'd1;
            end
          end
        end
        ST_CAND: begin
          if (result == RES_SINGLE && key == cand) begin
            if (cnt_inc >= DF) begin
              state_n = ST_PRESSED;
              code_n  = cand;
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_PRESSED: begin
          if (result == RES_NONE) begin
            if (DF <= 4'd1) begin
              state_n = ST_IDLE;
              held_n  = 1'b0;
              cnt_n   = '0;
            end else begin
              state_n = ST_REL;
              cnt_n   = 4'd1;
            end
          end
        end
        ST_REL: begin
          if (result == RES_NONE) begin
            if (cnt_inc >= DF) begin
              state_n = ST_IDLE;
              held_n  = 1'b0;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = ST_PRESSED;
            cnt_n   = '0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/jianpan_saomiao.sv
// 4x4 keypad scanner: drives rows, synchronizes the column lines and
// classifies each full scan frame before handing it to the debouncer.
module jianpan_saomiao
  import jianpan_saomiao_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 16,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic          active;
  logic [DW-1:0] dwell;
  logic [1:0]    idx;
  logic [3:0]    col_s1, col_s2;
  logic [1:0]    low_cnt;
  logic [3:0]    acc_key;

  logic [3:0]    hits;
  logic [2:0]    row_cnt, sum;
  logic [1:0]    row_col, merged_cnt;
  logic [3:0]    merged_key;
  logic          sample, frame_strobe;
  frame_res_e    result;

  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
    end
  end

  // active lags en by one edge so the first row appears one cycle after enable.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      active  <= 1'b0;
      dwell   <= '0;
      idx     <= '0;
      low_cnt <= '0;
      acc_key <= '0;
    end else begin
      active <= 1'b1;
      if (active) begin
        if (dwell == DWELL_LAST) begin
          dwell <= '0;
          idx   <= idx + 2'd1;
        end else begin
          dwell <= dwell + DW'(1);
        end
        if (sample) begin
          if (idx == 2'd3) begin
            low_cnt <= '0;
            acc_key <= '0;
          end else begin
            low_cnt <= merged_cnt;
            acc_key <= merged_key;
          end
        end
      end
    end
  end

  always_comb begin
    row = active ? row_drive(idx) : ROW_IDLE;
  end

  // Low-bit count saturates at 2: anything beyond one key is ghosting-ambiguous.
  always_comb begin
    hits    = ~col_s2;
    row_cnt = '0;
    row_col = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      if (hits[c]) begin
        row_cnt = row_cnt + 3'd1;
        row_col = 2'(c);
      end
    end
    sum        = {1'b0, low_cnt} + row_cnt;
    merged_cnt = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    merged_key = (low_cnt == 2'd0 && row_cnt == 3'd1) ? {idx, row_col} : acc_key;
    sample       = active && (dwell == DWELL_LAST);
    frame_strobe = sample && (idx == 2'd3);
    if (merged_cnt == 2'd0) begin
      result = RES_NONE;
    end else if (merged_cnt == 2'd1) begin
      result = RES_SINGLE;
    end else begin
      result = RES_MULTI;
    end
  end

  anjian_xiaodou #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_xiaodou (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .frame_strobe(frame_strobe),
    .result      (result),
    .key         (merged_key),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held)
  );

endmodule
